fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters: scan-out reads from the signal generator and pixel writes from the instruction decoder.
- Scan-out reads always win the RAM port, because display timing cannot stall.
- Pixel writes are converted from (x,y) to a linear address and queued in a small write FIFO.
- The FIFO drains into cycles where no read is requested. The block sits between instruction_decoder / signal_generator and the framebuffer RAM inside vga_gpu.

Parameters:
- FB_WIDTH, 160, framebuffer width in pixels; x must be < FB_WIDTH.
- FB_HEIGHT, 120, framebuffer height in lines; y must be < FB_HEIGHT.
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= FB_WIDTH*FB_HEIGHT.
- FIFO_DEPTH, 4, write FIFO entries; power of two, >= 2.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_rd_req  in  1  scan-out read request, sampled every cycle.
- i_rd_addr  in  ADDR_W  scan-out read address.
- o_rd_data  out  12  read pixel colour {R,G,B} 4 bits each.
- o_rd_valid  out  1  o_rd_data valid, 1-cycle pulse per read.
- i_set_pixel  in  1  pixel write strobe, 1 cycle per pixel.
- i_pixel_x  in  10  write x coordinate.
- i_pixel_y  in  10  write y coordinate.
- i_color  in  12  write colour.
- o_busy  out  1  write FIFO full; the decoder must hold off.
- o_mem_addr  out  ADDR_W  RAM address (registered).
- o_mem_we  out  1  RAM write enable (registered).
- o_mem_wdata  out  12  RAM write data (registered).
- i_mem_rdata  in  12  RAM read data, valid 1 cycle after the address edge.

Behaviour:
- Reset (async, immediate):
  - o_mem_addr=0, o_mem_we=0, o_mem_wdata=0, o_rd_data=0, o_rd_valid=0, o_busy=0.
  - FIFO empty, read pipeline flags cleared.
- Reset mid-operation: queued writes are discarded; an in-flight read produces no o_rd_valid.
- Enqueue:
  - On an edge with i_set_pixel=1, x<FB_WIDTH, y<FB_HEIGHT and FIFO not full, push {addr=y*FB_WIDTH+x truncated to ADDR_W, color}.
  - Out-of-range coordinates are silently dropped.
  - A strobe while full is dropped, even if a pop happens on the same edge. Fullness is evaluated before the pop.
- Arbitration, one grant per cycle, evaluated each edge:
  - READ if i_rd_req=1.
  - else WRITE if FIFO non-empty.
  - else IDLE.
- Grant outputs, registered at the same edge:
  - READ: o_mem_addr<=i_rd_addr, o_mem_we<=0.
  - WRITE: o_mem_addr<=head.addr, o_mem_wdata<=head.color, o_mem_we<=1, pop FIFO.
  - IDLE: o_mem_we<=0; o_mem_addr and o_mem_wdata hold.
- Read latency:
  - Request sampled at edge k; RAM samples address at edge k+1.
  - o_rd_data<=i_mem_rdata and o_rd_valid=1 after edge k+2, for exactly one cycle per granted read.
  - Back-to-back reads give back-to-back valid pulses.
- Write latency: a pixel strobed at edge k with an empty FIFO and no read at edge k+1 appears on o_mem_we after edge k+1.
- Write ordering: writes leave in FIFO order. A write and a read to the same address in the same cycle cannot both be granted; the read wins and the write stays queued.
- Starvation: continuous i_rd_req holds writes in the FIFO. Drain happens in horizontal/vertical blanking, where scan-out deasserts i_rd_req.
- o_busy: registered, equals FIFO count==FIFO_DEPTH after each edge.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits, wrap naturally; count = wr_ptr-rd_ptr.

Optional Feature:
- Macro FB_PORT_ARBITER_DROP_CNT_EN.
- Defined:
  - Adds output o_drop_count (16 bits), reset 0.
  - Increments by 1 for every i_set_pixel strobe that is dropped, whether from a full FIFO or out-of-range coordinates.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then i_set_pixel with x=3, y=2, color=12'hF00, no reads -> next cycle o_mem_we=1, o_mem_addr=323, o_mem_wdata=12'hF00; o_busy stays 0.
- i_rd_req=1 with i_rd_addr=100 for one cycle, RAM model returns 12'h0A5 -> o_rd_valid=1 with o_rd_data=12'h0A5 exactly 2 cycles after the request edge; no o_mem_we.
- i_rd_req held high, 5 pixel strobes, FIFO_DEPTH=4 -> o_busy=1 after the 4th, 5th dropped (o_drop_count=1 if enabled). Release i_rd_req -> 4 consecutive writes in order, o_busy=0 after the first pop.
- Pixel x=160, y=0 and x=0, y=120 -> no enqueue, no RAM write (o_drop_count=2 if enabled).
- Same edge: i_rd_req=1 and FIFO non-empty -> read granted, write issued on the first cycle with i_rd_req=0.
- Assert i_reset with 3 queued writes and a read in flight -> all outputs 0 immediately, no o_rd_valid, no further o_mem_we after release.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port synchronous framebuffer RAM between
// scan-out reads and queued pixel writes. Reads always win the port; pixel
// writes are linearised to y*FB_WIDTH+x, queued in a small FIFO, and drained
// into cycles with no read request.
//
// Optional build macro FB_PORT_ARBITER_DROP_CNT_EN adds o_drop_count, a
// saturating count of pixel strobes that were dropped (FIFO full or
// coordinates off-screen).
module fb_port_arbiter #(
  parameter int FB_WIDTH   = 160,
  parameter int FB_HEIGHT  = 120,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [11:0]       o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_set_pixel,
  input  logic [9:0]        i_pixel_x,
  input  logic [9:0]        i_pixel_y,
  input  logic [11:0]       i_color,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [11:0]       o_mem_wdata,
  input  logic [11:0]       i_mem_rdata
`ifdef FB_PORT_ARBITER_DROP_CNT_EN
  ,
  output logic [15:0]       o_drop_count
`endif
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } gnt_e;

  // Write FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [11:0]       fifo_col_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count;
  logic              full, empty;

  // RAM-side registers
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [11:0]       mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;

  // Read return path: [0] = address on RAM pins, [1] = data on RAM output
  logic [1:0]        vld_pipe_q;
  logic              rd_valid_q;
  logic [11:0]       rd_data_q;

  gnt_e              gnt;
  logic              push, pop;
  logic              in_range;
  logic [31:0]       x_ext, y_ext;
  logic [ADDR_W-1:0] push_addr;

  assign x_ext     = {22'd0, i_pixel_x};
  assign y_ext     = {22'd0, i_pixel_y};
  assign in_range  = (x_ext < 32'(FB_WIDTH)) && (y_ext < 32'(FB_HEIGHT));
  assign push_addr = ADDR_W'(y_ext * 32'(FB_WIDTH) + x_ext);

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == PTR_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Grant selection, FIFO pointer update and next RAM-side register values
  always_comb begin
    gnt         = GNT_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    if (i_rd_req) begin
      gnt        = GNT_READ;
      mem_addr_d = i_rd_addr;
    end else if (!empty) begin
      gnt         = GNT_WRITE;
      mem_addr_d  = fifo_addr_q[rd_ptr_q[IDX_W-1:0]];
      mem_wdata_d = fifo_col_q[rd_ptr_q[IDX_W-1:0]];
      mem_we_d    = 1'b1;
    end
    // fullness is judged before this edge's pop, so a strobe while full drops
    push     = i_set_pixel && in_range && !full;
    pop      = (gnt == GNT_WRITE);
    wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
    busy_d   = ((wr_ptr_d - rd_ptr_d) == PTR_W'(FIFO_DEPTH));
  end

  // FIFO storage; contents are don't-care while the slot is unused
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q[IDX_W-1:0]] <= push_addr;
      fifo_col_q[wr_ptr_q[IDX_W-1:0]]  <= i_color;
    end
  end

  // Control state and registered RAM interface
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  // Read return: grant edge -> RAM samples address -> capture RAM data
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_pipe_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], (gnt == GNT_READ)};
      rd_valid_q <= vld_pipe_q[1];
      if (vld_pipe_q[1]) rd_data_q <= i_mem_rdata;
    end
  end

`ifdef FB_PORT_ARBITER_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q;

  assign drop = i_set_pixel && !push;

  // Saturating count of rejected pixel strobes
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                              drop_cnt_q <= '0;
    else if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign o_drop_count = drop_cnt_q;
`endif

  assign o_mem_addr  = mem_addr_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_busy      = busy_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed stimulus, a queue-based reference model
// checked every cycle, a behavioural single-port RAM, and literal spot checks.
module tb_fb_port_arbiter;
  localparam int FB_W  = 160;
  localparam int FB_H  = 120;
  localparam int AW    = 15;
  localparam int DEPTH = 4;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_rd_req;
  logic [AW-1:0] i_rd_addr;
  logic [11:0]   o_rd_data;
  logic          o_rd_valid;
  logic          i_set_pixel;
  logic [9:0]    i_pixel_x, i_pixel_y;
  logic [11:0]   i_color;
  logic          o_busy;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_we;
  logic [11:0]   o_mem_wdata;
  logic [11:0]   i_mem_rdata = 12'h000;
`ifdef FB_PORT_ARBITER_DROP_CNT_EN
  logic [15:0]   o_drop_count;
`endif

  fb_port_arbiter #(.FB_WIDTH(FB_W), .FB_HEIGHT(FB_H), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_set_pixel(i_set_pixel),
    .i_pixel_x(i_pixel_x), .i_pixel_y(i_pixel_y), .i_color(i_color), .o_busy(o_busy),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
`ifdef FB_PORT_ARBITER_DROP_CNT_EN
    , .o_drop_count(o_drop_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Power-up RAM contents: addr[11:0]^0x0C1 (so address 100 holds 0x0A5)
  function automatic logic [11:0] init_val(input logic [AW-1:0] a);
    return a[11:0] ^ 12'h0C1;
  endfunction

  // Behavioural RAM: one port, write or read each edge, data one cycle later
  logic [11:0] ram     [1<<AW] = '{default: 12'h000};
  bit          ram_wr  [1<<AW] = '{default: 1'b0};
  always @(posedge i_clk) begin
    if (o_mem_we) begin
      ram[o_mem_addr]    <= o_mem_wdata;
      ram_wr[o_mem_addr] <= 1'b1;
    end
    i_mem_rdata <= ram_wr[o_mem_addr] ? ram[o_mem_addr] : init_val(o_mem_addr);
  end

  // ---------------- reference model ----------------
  typedef struct { logic [AW-1:0] addr; logic [11:0] color; } wr_t;
  typedef struct { int due; logic [11:0] data; } rd_t;
  wr_t wq[$];
  rd_t pend[$];
  logic [11:0] shadow    [1<<AW] = '{default: 12'h000};
  bit          shadow_wr [1<<AW] = '{default: 1'b0};
  int          cyc;
  logic          exp_we, exp_rd_valid, exp_busy;
  logic [AW-1:0] exp_addr;
  logic [11:0]   exp_wdata, exp_rd_data;
  logic [15:0]   exp_drops;

  function automatic logic [11:0] shadow_rd(input logic [AW-1:0] a);
    return shadow_wr[a] ? shadow[a] : init_val(a);
  endfunction

  task automatic model_edge();
    int  n0;
    bit  was_full, do_pop;
    wr_t e;
    n0       = wq.size();
    was_full = (n0 == DEPTH);
    do_pop   = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rd_valid <= 1'b1;
      exp_rd_data  <= pend[0].data;
      void'(pend.pop_front());
    end else begin
      exp_rd_valid <= 1'b0;
    end
    if (i_rd_req) begin
      exp_we   <= 1'b0;
      exp_addr <= i_rd_addr;
      pend.push_back('{due: cyc + 2, data: shadow_rd(i_rd_addr)});
    end else if (n0 > 0) begin
      e         = wq[0];
      do_pop    = 1'b1;
      exp_we    <= 1'b1;
      exp_addr  <= e.addr;
      exp_wdata <= e.color;
      shadow[e.addr]    <= e.color;
      shadow_wr[e.addr] <= 1'b1;
    end else begin
      exp_we <= 1'b0;
    end
    if (i_set_pixel) begin
      if (int'(i_pixel_x) < FB_W && int'(i_pixel_y) < FB_H && !was_full)
        wq.push_back('{addr: AW'(int'(i_pixel_y) * FB_W + int'(i_pixel_x)), color: i_color});
      else if (exp_drops != 16'hFFFF)
        exp_drops <= exp_drops + 16'd1;
    end
    if (do_pop) void'(wq.pop_front());
    exp_busy <= (wq.size() == DEPTH);
    cyc      <= cyc + 1;
  endtask

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wq.delete();
      pend.delete();
      exp_we <= 1'b0; exp_addr <= '0; exp_wdata <= '0;
      exp_rd_valid <= 1'b0; exp_rd_data <= '0; exp_busy <= 1'b0;
      exp_drops <= '0; cyc <= 0;
    end else begin
      model_edge();
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge i_clk) begin
    if (chk_en && !i_reset) begin
      check("mem_we", 32'(o_mem_we), 32'(exp_we));
      check("mem_addr", 32'(o_mem_addr), 32'(exp_addr));
      check("mem_wdata", 32'(o_mem_wdata), 32'(exp_wdata));
      check("rd_valid", 32'(o_rd_valid), 32'(exp_rd_valid));
      check("rd_data", 32'(o_rd_data), 32'(exp_rd_data));
      check("busy", 32'(o_busy), 32'(exp_busy));
`ifdef FB_PORT_ARBITER_DROP_CNT_EN
      check("drop_count", 32'(o_drop_count), 32'(exp_drops));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic [11:0] c);
    i_set_pixel = 1'b1;
    i_pixel_x   = 10'(x);
    i_pixel_y   = 10'(y);
    i_color     = c;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_we"}, 32'(o_mem_we), 32'd0);
    check({tag, "_addr"}, 32'(o_mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(o_mem_wdata), 32'd0);
    check({tag, "_rd_valid"}, 32'(o_rd_valid), 32'd0);
    check({tag, "_rd_data"}, 32'(o_rd_data), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
`ifdef FB_PORT_ARBITER_DROP_CNT_EN
    check({tag, "_drops"}, 32'(o_drop_count), 32'd0);
`endif
  endtask

  initial begin
    i_reset = 1'b1; i_rd_req = 1'b0; i_rd_addr = '0;
    i_set_pixel = 1'b0; i_pixel_x = '0; i_pixel_y = '0; i_color = '0;
    #3;
    check_zero_outputs("reset");
    step(); step();
    i_reset = 1'b0;
    chk_en  = 1'b1;
    step();

    // single pixel write, empty FIFO, no reads
    pix(3, 2, 12'hF00);
    step();
    i_set_pixel = 1'b0;
    step();
    check("w1_we", 32'(o_mem_we), 32'd1);
    check("w1_addr", 32'(o_mem_addr), 32'd323);
    check("w1_wdata", 32'(o_mem_wdata), 32'hF00);
    check("w1_busy", 32'(o_busy), 32'd0);
    step();
    check("w1_we_done", 32'(o_mem_we), 32'd0);

    // single read, two-edge latency
    i_rd_req = 1'b1; i_rd_addr = AW'(100);
    step();
    i_rd_req = 1'b0;
    check("r1_we", 32'(o_mem_we), 32'd0);
    check("r1_addr", 32'(o_mem_addr), 32'd100);
    step();
    check("r1_early", 32'(o_rd_valid), 32'd0);
    step();
    check("r1_valid", 32'(o_rd_valid), 32'd1);
    check("r1_data", 32'(o_rd_data), 32'h0A5);
    step();
    check("r1_pulse", 32'(o_rd_valid), 32'd0);

    // reads held high: fill FIFO, fifth strobe dropped, then drain in order
    i_rd_req = 1'b1; i_rd_addr = AW'(200);
    for (int i = 0; i < 5; i++) begin
      pix(10 + i, i, 12'h100 + 12'(i));
      step();
      if (i == 3) check("fill_busy", 32'(o_busy), 32'd1);
    end
    i_set_pixel = 1'b0; i_rd_req = 1'b0;
    check("full_busy", 32'(o_busy), 32'd1);
    check("full_no_we", 32'(o_mem_we), 32'd0);
`ifdef FB_PORT_ARBITER_DROP_CNT_EN
    check("drop_full", 32'(o_drop_count), 32'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_we", 32'(o_mem_we), 32'd1);
      check("drain_addr", 32'(o_mem_addr), 32'(i * 160 + 10 + i));
      check("drain_wdata", 32'(o_mem_wdata), 32'h100 + 32'(i));
      check("drain_busy", 32'(o_busy), 32'd0);
    end
    step();
    check("drain_end", 32'(o_mem_we), 32'd0);

    // out-of-range coordinates, then the last valid pixel
    pix(160, 0, 12'h0F0);
    step();
    pix(0, 120, 12'h00F);
    step();
    i_set_pixel = 1'b0;
    step();
    check("oor_we", 32'(o_mem_we), 32'd0);
    step();
    check("oor_we2", 32'(o_mem_we), 32'd0);
`ifdef FB_PORT_ARBITER_DROP_CNT_EN
    check("drop_oor", 32'(o_drop_count), 32'd3);
`endif
    pix(159, 119, 12'h777);
    step();
    i_set_pixel = 1'b0;
    step();
    check("edge_we", 32'(o_mem_we), 32'd1);
    check("edge_addr", 32'(o_mem_addr), 32'd19199);

    // read and queued write to the same address: read wins
    i_rd_req = 1'b1; i_rd_addr = AW'(805);
    pix(5, 5, 12'hABC);
    step();
    i_set_pixel = 1'b0;
    check("coll_we1", 32'(o_mem_we), 32'd0);
    step();
    check("coll_we2", 32'(o_mem_we), 32'd0);
    i_rd_req = 1'b0;
    step();
    check("coll_we3", 32'(o_mem_we), 32'd1);
    check("coll_addr", 32'(o_mem_addr), 32'd805);
    check("coll_wdata", 32'(o_mem_wdata), 32'hABC);
    step(); step();

    // reset mid-operation: three queued writes and reads in flight
    i_rd_req = 1'b1; i_rd_addr = AW'(50);
    for (int i = 0; i < 3; i++) begin
      pix(1 + i, 1, 12'h321);
      step();
    end
    i_set_pixel = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    check_zero_outputs("midrst");
    step(); step();
    i_reset  = 1'b0;
    i_rd_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_we", 32'(o_mem_we), 32'd0);
      check("post_rst_rv", 32'(o_rd_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
